// File: rtl/taxi_occupancy_tracker_if.sv
// taxi_occupancy_tracker_if: per-door beam samples in, merged occupancy status out
interface taxi_occupancy_tracker_if #(
  parameter int NUM_DOORS = 2,
  parameter int CAPACITY  = 4
);
  localparam int CNT_W = $clog2(CAPACITY + 1);
  logic [NUM_DOORS-1:0]   valid;
  logic [2*NUM_DOORS-1:0] in;
  logic [2:0]             incr_decr_error;
  logic [CNT_W-1:0]       occupancy;
  logic                   full;
  logic                   empty;
  logic [NUM_DOORS-1:0]   door_fault;
  modport master (output valid, in, input incr_decr_error, occupancy, full, empty, door_fault);
  modport slave  (input valid, in, output incr_decr_error, occupancy, full, empty, door_fault);
endinterface

// File: rtl/taxi_occupancy_tracker.sv
// taxi_occupancy_tracker: per-door two-beam FSMs merged into one saturating passenger count
module taxi_occupancy_tracker #(
  parameter int NUM_DOORS = 2,
  parameter int CAPACITY  = 4,
  parameter int TIMEOUT   = 16
) (
  input logic clk,
  input logic rst,
  taxi_occupancy_tracker_if.slave bus
);
  localparam int CNT_W = $clog2(CAPACITY + 1);
  localparam int NW    = CNT_W + $clog2(NUM_DOORS) + 2;
  localparam int TW    = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ENT_A, ENT_AB, ENT_B, EXT_B, EXT_BA, EXT_A, FAULT} state_t;
  typedef struct packed {
    state_t s;
    logic   ent;
    logic   ext;
    logic   err;
  } tr_t;
  state_t                 state_q [NUM_DOORS];
  state_t                 state_d [NUM_DOORS];
  logic [TW-1:0]          timer_q [NUM_DOORS];
  logic [TW-1:0]          timer_d [NUM_DOORS];
  tr_t                    tr      [NUM_DOORS];
  logic [NUM_DOORS-1:0]   hold;
  logic [NUM_DOORS-1:0]   to;
  logic [CNT_W-1:0]       occupancy_q, occupancy_d;
  logic [2:0]             flags_q, flags_d;
  logic signed [NW-1:0]   net_d, nxt;
  logic                   err_d, rej;
  // Sampled ab is {B, A}; entry walks A -> AB -> B -> clear, exit is the mirror image.
  function automatic tr_t step(input state_t cur, input logic [1:0] ab);
    tr_t t;
    t = tr_t'{cur, 1'b0, 1'b0, 1'b0};
    case (cur)
      IDLE:    t.s = ab == 2'b01 ? ENT_A  : ab == 2'b10 ? EXT_B : ab == 2'b11 ? FAULT : IDLE;
      ENT_A:   t.s = ab == 2'b11 ? ENT_AB : ab == 2'b00 ? IDLE  : ab == 2'b10 ? FAULT : ENT_A;
      ENT_AB:  t.s = ab == 2'b10 ? ENT_B  : ab == 2'b01 ? ENT_A : ab == 2'b00 ? FAULT : ENT_AB;
      ENT_B:   t.s = ab == 2'b00 ? IDLE   : ab == 2'b11 ? ENT_AB : ab == 2'b01 ? FAULT : ENT_B;
      EXT_B:   t.s = ab == 2'b11 ? EXT_BA : ab == 2'b00 ? IDLE  : ab == 2'b01 ? FAULT : EXT_B;
      EXT_BA:  t.s = ab == 2'b01 ? EXT_A  : ab == 2'b10 ? EXT_B : ab == 2'b00 ? FAULT : EXT_BA;
      EXT_A:   t.s = ab == 2'b00 ? IDLE   : ab == 2'b11 ? EXT_BA : ab == 2'b10 ? FAULT : EXT_A;
      default: t.s = ab == 2'b00 ? IDLE   : FAULT;
    endcase
    t.err = cur != FAULT && t.s == FAULT;
    t.ent = cur == ENT_B && ab == 2'b00;
    t.ext = cur == EXT_A && ab == 2'b00;
    return t;
  endfunction
  always_comb begin
    net_d = '0;
    err_d = 1'b0;
    for (int d = 0; d < NUM_DOORS; d++) begin
      tr[d]      = bus.valid[d] ? step(state_q[d], bus.in[2*d +: 2]) : tr_t'{state_q[d], 1'b0, 1'b0, 1'b0};
      hold[d]    = state_q[d] != IDLE && state_q[d] != FAULT && tr[d].s == state_q[d];
      to[d]      = hold[d] && timer_q[d] == TW'(TIMEOUT - 1);
      timer_d[d] = hold[d] && !to[d] ? timer_q[d] + 1'b1 : '0;
      state_d[d] = to[d] ? IDLE : tr[d].s;
      err_d      = err_d | tr[d].err | to[d];
      net_d      = net_d + (tr[d].ent ? NW'(1) : NW'(0)) - (tr[d].ext ? NW'(1) : NW'(0));
    end
    nxt         = net_d + $signed(NW'(occupancy_q));
    rej         = nxt[NW-1] || nxt > NW'(CAPACITY);
    occupancy_d = rej ? occupancy_q : nxt[CNT_W-1:0];
    flags_d     = {!rej && !net_d[NW-1] && net_d != '0, !rej && net_d[NW-1], err_d | rej};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= '{default: IDLE};
      timer_q     <= '{default: '0};
      occupancy_q <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      occupancy_q <= occupancy_d;
      flags_q     <= flags_d;
    end
  end
  assign bus.incr_decr_error = flags_q;
  assign bus.occupancy       = occupancy_q;
  assign bus.full            = occupancy_q == CNT_W'(CAPACITY);
  assign bus.empty           = occupancy_q == '0;
  for (genvar g = 0; g < NUM_DOORS; g++) begin : g_fault
    assign bus.door_fault[g] = state_q[g] == FAULT;
  end
endmodule

// File: tb/tb_taxi_occupancy_tracker.sv
// tb_taxi_occupancy_tracker: directed door sequences against hand-computed occupancy and flags
module tb_taxi_occupancy_tracker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  taxi_occupancy_tracker_if #(.NUM_DOORS(2), .CAPACITY(4)) bus ();
  taxi_occupancy_tracker #(.NUM_DOORS(2), .CAPACITY(4), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic expect_out(input string tag, input logic [2:0] f, input int occ, input logic [1:0] df);
    chk({tag, ":flags"}, 8'(bus.incr_decr_error), 8'(f));
    chk({tag, ":occ"}, 8'(bus.occupancy), 8'(occ));
    chk({tag, ":full"}, 8'(bus.full), 8'(occ == 4));
    chk({tag, ":empty"}, 8'(bus.empty), 8'(occ == 0));
    chk({tag, ":fault"}, 8'(bus.door_fault), 8'(df));
  endtask
  task automatic step(input logic [1:0] v, input logic [3:0] i);
    @(negedge clk);
    bus.valid = v;
    bus.in = i;
    @(posedge clk);
    #1;
  endtask
  task automatic enter0;
    step(2'b01, 4'b0001);
    step(2'b01, 4'b0011);
    step(2'b01, 4'b0010);
    step(2'b01, 4'b0000);
  endtask
  task automatic exit1;
    step(2'b10, 4'b1000);
    step(2'b10, 4'b1100);
    step(2'b10, 4'b0100);
    step(2'b10, 4'b0000);
  endtask
  task automatic both;
    step(2'b11, 4'b1001);
    step(2'b11, 4'b1111);
    step(2'b11, 4'b0110);
    step(2'b11, 4'b0000);
  endtask
  initial begin
    bus.valid = '0;
    bus.in = '0;
    #3 expect_out("reset", 3'b000, 0, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    step(2'b01, 4'b0001);
    step(2'b01, 4'b0011);
    step(2'b01, 4'b0010);
    expect_out("t1_mid", 3'b000, 0, 2'b00);
    step(2'b01, 4'b0000);
    expect_out("t1_incr", 3'b100, 1, 2'b00);
    step(2'b00, 4'b0000);
    expect_out("t1_pulse_end", 3'b000, 1, 2'b00);
    enter0;
    expect_out("occ2", 3'b100, 2, 2'b00);
    enter0;
    enter0;
    expect_out("occ4_full", 3'b100, 4, 2'b00);
    enter0;
    expect_out("t2_overflow", 3'b001, 4, 2'b00);
    step(2'b00, 4'b0000);
    expect_out("t2_quiet", 3'b000, 4, 2'b00);
    exit1;
    expect_out("exit_occ3", 3'b010, 3, 2'b00);
    exit1;
    expect_out("exit_occ2", 3'b010, 2, 2'b00);
    both;
    expect_out("t3_both_occ2", 3'b000, 2, 2'b00);
    exit1;
    exit1;
    expect_out("exit_occ0", 3'b010, 0, 2'b00);
    both;
    expect_out("t3_both_occ0", 3'b000, 0, 2'b00);
    exit1;
    expect_out("underflow", 3'b001, 0, 2'b00);
    step(2'b10, 4'b1000);
    step(2'b10, 4'b0000);
    expect_out("t4_abort", 3'b000, 0, 2'b00);
    step(2'b10, 4'b1100);
    expect_out("t4_fault", 3'b001, 0, 2'b10);
    step(2'b10, 4'b0100);
    expect_out("t4_fault_hold", 3'b000, 0, 2'b10);
    step(2'b10, 4'b0000);
    expect_out("t4_fault_clear", 3'b000, 0, 2'b00);
    step(2'b01, 4'b0001);
    repeat (15) step(2'b00, 4'b0000);
    expect_out("t5_before", 3'b000, 0, 2'b00);
    step(2'b00, 4'b0000);
    expect_out("t5_timeout", 3'b001, 0, 2'b00);
    step(2'b01, 4'b0010);
    expect_out("t5_idle_probe", 3'b000, 0, 2'b00);
    step(2'b01, 4'b0000);
    expect_out("t5_probe_abort", 3'b000, 0, 2'b00);
    enter0;
    enter0;
    enter0;
    enter0;
    expect_out("t6_occ4", 3'b100, 4, 2'b00);
    step(2'b11, 4'b1001);
    step(2'b11, 4'b1111);
    step(2'b11, 4'b0111);
    step(2'b11, 4'b0011);
    expect_out("t6_pre", 3'b010, 3, 2'b00);
    #2 rst = 1'b0;
    #1 expect_out("t6_async_reset", 3'b000, 0, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    step(2'b01, 4'b0010);
    step(2'b01, 4'b0000);
    expect_out("t6_no_incr", 3'b000, 0, 2'b00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
